aes_ctr_stream: RTL and testbench



---
 rtl/aes_ctr_stream_if.sv | 20 ++
 rtl/AES_Encrypt.sv | 105 ++++++++++
 rtl/aes_ctr_stream.sv | 97 +++++++++
 tb/tb_aes_ctr_stream.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_stream_if.sv
// Block streams around the CTR engine: s_* carries blocks in, m_* carries results out.
// The engine uses the slave view; the producer/consumer side uses the master view.
interface aes_ctr_stream_if;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/AES_Encrypt.sv
// Purpose: combinational AES block encryption with full key expansion (128/192/256-bit keys).
// Latency: zero cycles, output is a pure function of key and plaintext.
// Backpressure: none, no state and no handshake.
module AES_Encrypt #(
  parameter int KEY_BITS = 128,
  parameter int NR       = 10,
  parameter int NK       = 4
) (
  input  logic [KEY_BITS-1:0] key,
  input  logic [127:0]        plaintext,
  output logic [127:0]        ciphertext
);
  localparam int NW = 4 * (NR + 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] t;
    inv = 8'h01;
    t   = x;
    for (int i = 1; i < 8; i++) begin
      t   = gmul(t, t);
      inv = gmul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [127:0] encrypt(input logic [KEY_BITS-1:0] k, input logic [127:0] pt);
    logic [31:0]         w [NW];
    logic [KEY_BITS-1:0] kk;
    logic [31:0]         t;
    logic [7:0]          rc;
    logic [7:0]          st [16];
    logic [7:0]          sh [16];
    logic [7:0]          a0, a1, a2, a3;
    logic [127:0]        rk;
    logic [127:0]        res;
    kk = k;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) begin
      w[i] = kk[KEY_BITS-1 -: 32];
      kk   = kk << 32;
    end
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    rk = {w[0], w[1], w[2], w[3]};
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= NR; r++) begin
      // Byte i sits at row i%4, column i/4; ShiftRows pulls from column (col+row)%4.
      for (int i = 0; i < 16; i++) sh[i] = sub_byte(st[4*((i/4 + i%4) % 4) + i%4]);
      for (int c = 0; c < 4; c++) begin
        a0 = sh[4*c];
        a1 = sh[4*c+1];
        a2 = sh[4*c+2];
        a3 = sh[4*c+3];
        if (r == NR) begin
          st[4*c]   = a0;
          st[4*c+1] = a1;
          st[4*c+2] = a2;
          st[4*c+3] = a3;
        end else begin
          st[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          st[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  assign ciphertext = encrypt(key, plaintext);
endmodule

// File: rtl/aes_ctr_stream.sv
// Purpose: AES-CTR stream engine; XORs each input block with AES(key, ctr) and bumps the counter.
// Latency: one cycle from accept to m_valid, full throughput through a single output register.
// Backpressure: s_ready drops while the output register is held or a key/ctr load is in progress.
module aes_ctr_stream #(
  parameter int KEY_BITS = 128,
  parameter int NR       = 10,
  parameter int NK       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_load,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                ctr_load,
  input  logic [127:0]        ctr_in,
  aes_ctr_stream_if.slave     io,
  output logic [31:0]         blk_count,
  output logic                armed
);
  typedef enum logic {UNARMED, ARMED} state_t;

  state_t              state, state_nxt;
  logic                key_seen, ctr_seen;
  logic [KEY_BITS-1:0] key_reg;
  logic [127:0]        ctr_reg;
  logic [127:0]        keystream;
  logic [127:0]        m_data_q;
  logic                m_valid_q;
  logic                s_ready_c;
  logic                accept;

  AES_Encrypt #(
    .KEY_BITS (KEY_BITS),
    .NR       (NR),
    .NK       (NK)
  ) u_aes (
    .key        (key_reg),
    .plaintext  (ctr_reg),
    .ciphertext (keystream)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= UNARMED;
    else       state <= state_nxt;
  end

  // Loads block acceptance so no block ever sees a half-updated key/counter pair.
  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    case (state)
      UNARMED: if ((key_seen || key_load) && (ctr_seen || ctr_load)) state_nxt = ARMED;
      ARMED:   s_ready_c = !key_load && !ctr_load && (!m_valid_q || io.m_ready);
      default: state_nxt = UNARMED;
    endcase
    accept = io.s_valid && s_ready_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg   <= '0;
      key_seen  <= 1'b0;
      ctr_reg   <= '0;
      ctr_seen  <= 1'b0;
      blk_count <= '0;
    end else begin
      if (key_load) begin
        key_reg  <= key_in;
        key_seen <= 1'b1;
      end
      if (ctr_load) begin
        ctr_reg   <= ctr_in;
        ctr_seen  <= 1'b1;
        blk_count <= '0;
      end else if (accept) begin
        ctr_reg   <= ctr_reg + 128'd1;
        blk_count <= blk_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= io.s_data ^ keystream;
    end else if (io.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign io.s_ready = s_ready_c;
  assign io.m_valid = m_valid_q;
  assign io.m_data  = m_data_q;
  assign armed      = (state == ARMED);
endmodule

// File: tb/tb_aes_ctr_stream.sv
// Bench for aes_ctr_stream: reference AES + CTR model checked every cycle, plus NIST literals.
module tb_aes_ctr_stream;
  localparam logic [127:0] K      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C      = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] PT1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT1    = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] CT2    = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load, ctr_load;
  logic [127:0] key_in, ctr_in;
  logic [31:0]  blk_count;
  logic         armed;

  aes_ctr_stream_if io();

  aes_ctr_stream dut (
    .clk       (clk),
    .reset     (reset),
    .key_load  (key_load),
    .key_in    (key_in),
    .ctr_load  (ctr_load),
    .ctr_in    (ctr_in),
    .io        (io),
    .blk_count (blk_count),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] out_q [$];
  int           out_cyc [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Table-driven AES-128 reference working on a byte-array state.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   rk [176];
    logic [7:0]   st [16];
    logic [7:0]   sh [16];
    logic [7:0]   t [4];
    logic [7:0]   rc, tmp, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) rk[i] = k[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = rk[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sbox_t[t[1]] ^ rc;
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[tmp];
        rc   = xt(rc);
      end
      for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ t[j];
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) sh[i] = sbox_t[st[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
        if (r < 10) begin
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Cycle-level expectation of the engine, stepped on each rising edge.
  logic [127:0] mdl_key, mdl_ctr, mdl_md;
  logic [31:0]  mdl_blk;
  logic         mdl_mv, mdl_ks, mdl_cs, mdl_armed, mdl_acc;
  logic         started = 1'b0;

  function automatic logic exp_ready();
    return mdl_armed && !key_load && !ctr_load && (!mdl_mv || io.m_ready);
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    started = 1'b1;
    if (reset) begin
      mdl_key = '0; mdl_ctr = '0; mdl_md = '0; mdl_blk = '0;
      mdl_mv = 1'b0; mdl_ks = 1'b0; mdl_cs = 1'b0; mdl_armed = 1'b0;
    end else begin
      mdl_acc = exp_ready() && io.s_valid;
      if (mdl_acc) begin
        mdl_md  = io.s_data ^ aes_ref(mdl_key, mdl_ctr);
        mdl_mv  = 1'b1;
        mdl_ctr = mdl_ctr + 1;
        mdl_blk = mdl_blk + 1;
      end else if (io.m_ready) begin
        mdl_mv = 1'b0;
      end
      if (key_load) begin mdl_key = key_in; mdl_ks = 1'b1; end
      if (ctr_load) begin mdl_ctr = ctr_in; mdl_blk = '0; mdl_cs = 1'b1; end
      mdl_armed = mdl_ks && mdl_cs;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("s_ready", io.s_ready, exp_ready());
      check("m_valid", io.m_valid, mdl_mv);
      check("armed", armed, mdl_armed);
      check("blk_count", blk_count, mdl_blk);
      check("m_data", io.m_data, mdl_md);
      if (!reset && io.m_valid && io.m_ready) begin
        out_q.push_back(io.m_data);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic kl, input logic [127:0] k, input logic cl, input logic [127:0] c);
    key_load = kl; key_in = k; ctr_load = cl; ctr_in = c;
    tick();
    key_load = 1'b0; ctr_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input string nm);
    logic done;
    done = 1'b0;
    io.s_valid = 1'b1;
    io.s_data  = d;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (io.s_ready) done = 1'b1;
      tick();
    end
    io.s_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: block not accepted within 40 cycles", nm);
    end
  endtask

  task automatic wait_out(input int n, input string nm);
    for (int k = 0; k < 20 && out_q.size() < n; k++) tick();
    tick(); tick();
    check({nm, " output count"}, out_q.size(), n);
  endtask

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] ones;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1); q = q ^ (q << 2); q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;

    check("model fips197", aes_ref(FIPS_K, FIPS_P), FIPS_C);
    check("model ctr blk1", aes_ref(K, C) ^ PT1, CT1);
    check("model ctr blk2", aes_ref(K, C + 128'd1) ^ PT2, CT2);

    reset = 1'b1; key_load = 1'b0; ctr_load = 1'b0; key_in = '0; ctr_in = '0;
    io.s_valid = 1'b0; io.s_data = '0; io.m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Unarmed: input offered but ignored.
    io.s_valid = 1'b1; io.s_data = PT1; io.m_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("unarmed s_ready", io.s_ready, 0);
    check("unarmed m_valid", io.m_valid, 0);
    check("unarmed armed", armed, 0);
    check("unarmed blk_count", blk_count, 0);
    tick();
    io.s_valid = 1'b0;

    // NIST SP800-38A CTR-AES128 encrypt, back to back.
    load(1'b1, K, 1'b0, '0);
    load(1'b0, '0, 1'b1, C);
    out_q.delete(); out_cyc.delete();
    send(PT1, "enc blk1"); send(PT2, "enc blk2");
    wait_out(2, "enc");
    if (out_q.size() == 2) begin
      check("enc out1", out_q[0], CT1);
      check("enc out2", out_q[1], CT2);
      check("enc consecutive", out_cyc[1] - out_cyc[0], 1);
    end
    check("enc blk_count", blk_count, 2);

    // Decrypt by reloading the counter and feeding ciphertext back.
    load(1'b0, '0, 1'b1, C);
    out_q.delete(); out_cyc.delete();
    send(CT1, "dec blk1"); send(CT2, "dec blk2");
    wait_out(2, "dec");
    if (out_q.size() == 2) begin
      check("dec out1", out_q[0], PT1);
      check("dec out2", out_q[1], PT2);
    end

    // Backpressure with a key reload while the first result is held.
    load(1'b0, '0, 1'b1, C);
    out_q.delete(); out_cyc.delete();
    io.m_ready = 1'b0;
    send(PT1, "bp blk1");
    io.s_valid = 1'b1; io.s_data = PT2;
    for (int i = 0; i < 5; i++) begin
      key_load = (i == 2); key_in = K;
      @(negedge clk);
      check("bp s_ready held low", io.s_ready, 0);
      check("bp m_data stable", io.m_data, CT1);
      check("bp m_valid held", io.m_valid, 1);
      tick();
    end
    key_load = 1'b0;
    io.m_ready = 1'b1;
    send(PT2, "bp blk2");
    wait_out(2, "bp");
    if (out_q.size() == 2) begin
      check("bp out1", out_q[0], CT1);
      check("bp out2", out_q[1], CT2);
      check("bp consecutive", out_cyc[1] - out_cyc[0], 1);
    end

    // 128-bit counter wrap.
    ones = '1;
    load(1'b0, '0, 1'b1, ones);
    out_q.delete(); out_cyc.delete();
    send(PT1, "wrap blk1"); send(PT2, "wrap blk2");
    wait_out(2, "wrap");
    if (out_q.size() == 2) begin
      check("wrap out1", out_q[0], PT1 ^ aes_ref(K, ones));
      check("wrap out2", out_q[1], PT2 ^ aes_ref(K, 128'd0));
    end
    check("wrap blk_count", blk_count, 2);

    // Reset while a result is stalled, then rearm with a simultaneous key+ctr load.
    load(1'b0, '0, 1'b1, C);
    io.m_ready = 1'b0;
    send(PT1, "rst blk1");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst m_valid", io.m_valid, 0);
    check("rst armed", armed, 0);
    check("rst blk_count", blk_count, 0);
    check("rst m_data", io.m_data, 0);
    tick();
    load(1'b1, K, 1'b1, C);
    io.m_ready = 1'b1;
    out_q.delete(); out_cyc.delete();
    send(PT1, "rearm blk1");
    wait_out(1, "rearm");
    if (out_q.size() == 1) check("rearm out1", out_q[0], CT1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
